// File: rtl/keypad_time_entry.sv
// Keypad receiver: debounces priority-encoder presses into a four-digit BCD MM:SS
// entry register and hands the entry to the cook timer with a one-cycle loadn strobe.
module keypad_time_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       validn,
  input  logic       clear,
  input  logic       start,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       beep,
  output logic       loadn
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD,
    RELEASE
  } state_e;

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  cap_q, cap_d;

  logic [15:0] time_q, time_d;
  logic [2:0]  count_q, count_d;
  logic        beep_q, beep_d;
  logic        loadn_q, loadn_d;
  logic        pend_q, pend_d;

  logic        key_ok;
  logic        match;
  logic        stall;
  logic        accept;
  logic        shift;
  logic        start_go;

  assign key_ok = !validn && (digit <= 4'd9);
  assign match  = key_ok && (digit == cap_q);
  // The press detector freezes while the timer captures, so an accept lands after the clear.
  assign stall  = !loadn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    case (state_q)
      IDLE: begin
        if (key_ok) begin
          cap_d   = digit;
          cnt_d   = 8'd1;
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (!stall) begin
          if (match) begin
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      HELD: begin
        if (validn) begin
          cnt_d   = 8'd1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!validn) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    accept = (state_q == PRESS) && !stall && match && (cnt_q == LAST);
  end

  assign shift    = accept && (count_q < 3'd4) && !clear;
  assign start_go = start && !clear && !pend_q && loadn_q &&
                    ((count_q != 3'd0) || shift);

  always_comb begin
    time_d  = time_q;
    count_d = count_q;
    if (clear || !loadn_q) begin
      time_d  = '0;
      count_d = '0;
    end else if (shift) begin
      time_d  = {time_q[11:0], digit};
      count_d = count_q + 3'd1;
    end
    beep_d  = shift;
    loadn_d = !(pend_q && !clear);
    pend_d  = start_go;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q  <= '0;
      count_q <= '0;
      beep_q  <= 1'b0;
      loadn_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      time_q  <= time_d;
      count_q <= count_d;
      beep_q  <= beep_d;
      loadn_q <= loadn_d;
      pend_q  <= pend_d;
    end
  end

  assign min_tens    = time_q[15:12];
  assign min_ones    = time_q[11:8];
  assign sec_tens    = time_q[7:4];
  assign sec_ones    = time_q[3:0];
  assign digit_count = count_q;
  assign beep        = beep_q;
  assign loadn       = loadn_q;

endmodule
